cpu_alu: RTL and testbench



---
 rtl/cpu_alu.sv | 63 ++++++
 tb/tb_cpu_alu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - registered 32-bit EX-stage ALU with HI/LO forwarding
// Optional signed slt on funct 42 is built only when CPU_ALU_SLT_EN is defined.
module cpu_alu (
    input  logic        clka,
    input  logic        reset,
    input  logic        imm_op,
    input  logic [31:0] rs,
    input  logic [31:0] alusrc,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [63:0] hilo,
    output logic [31:0] data_out,
    output logic        iszero
);

    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
`ifdef CPU_ALU_SLT_EN
    localparam logic [5:0] FN_SLT  = 6'd42;
`endif

    logic [31:0] result;

    always_comb begin
        result = 32'd0;
        if (imm_op) begin
            result = rs + alusrc;
        end else begin
            case (funct)
                FN_ADD, FN_ADDU: result = rs + alusrc;
                FN_SUB, FN_SUBU: result = rs - alusrc;
                FN_AND:          result = rs & alusrc;
                FN_OR:           result = rs | alusrc;
                FN_SRL:          result = alusrc >> shamt;
                FN_MFHI:         result = hilo[63:32];
                FN_MFLO:         result = hilo[31:0];
`ifdef CPU_ALU_SLT_EN
                FN_SLT:          result = {31'd0, ($signed(rs) < $signed(alusrc))};
`endif
                default:         result = 32'd0;
            endcase
        end
    end

    // Equality is independent of the selected op so beq can use it alongside the forced add.
    always_ff @(posedge clka) begin
        if (reset) begin
            data_out <= 32'd0;
            iszero   <= 1'b0;
        end else begin
            data_out <= result;
            iszero   <= (rs == alusrc);
        end
    end

endmodule

// File: tb/tb_cpu_alu.sv
// tb/tb_cpu_alu.sv - directed self-checking bench for cpu_alu
module tb_cpu_alu;

    logic        clka = 1'b0;
    logic        reset;
    logic        imm_op;
    logic [31:0] rs;
    logic [31:0] alusrc;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [63:0] hilo;
    logic [31:0] data_out;
    logic        iszero;

    int errors = 0;
    int checks = 0;

    cpu_alu dut (
        .clka     (clka),
        .reset    (reset),
        .imm_op   (imm_op),
        .rs       (rs),
        .alusrc   (alusrc),
        .funct    (funct),
        .shamt    (shamt),
        .hilo     (hilo),
        .data_out (data_out),
        .iszero   (iszero)
    );

    always #5 clka = ~clka;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic imm, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] fn, input logic [4:0] sh);
        imm_op = imm;
        rs     = a;
        alusrc = b;
        funct  = fn;
        shamt  = sh;
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    logic [31:0] exp_slt_lt;

    initial begin
        reset = 1'b1;
        hilo  = 64'h0;
        drive(1'b0, 32'd5, 32'd5, 6'd32, 5'd0);
        step();
        check_eq("reset_data", data_out, 32'd0);
        check_eq("reset_zero", iszero, 1'b0);

        reset = 1'b0;
        step();
        check_eq("post_reset_add", data_out, 32'd10);
        check_eq("post_reset_zero", iszero, 1'b1);

        drive(1'b0, 32'hFFFF_FFFF, 32'd1, 6'd32, 5'd0);
        step();
        check_eq("add_wrap", data_out, 32'h0000_0000);
        check_eq("add_wrap_zero", iszero, 1'b0);

        drive(1'b0, 32'd3, 32'd5, 6'd34, 5'd0);
        step();
        check_eq("sub_neg", data_out, 32'hFFFF_FFFE);
        check_eq("sub_neg_zero", iszero, 1'b0);

        drive(1'b0, 32'd9, 32'd4, 6'd35, 5'd0);
        step();
        check_eq("subu", data_out, 32'd5);

        drive(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd36, 5'd0);
        step();
        check_eq("and", data_out, 32'h00F0_00F0);

        drive(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd37, 5'd0);
        step();
        check_eq("or", data_out, 32'hFFF0_FFF0);

        drive(1'b0, 32'd0, 32'h8000_0000, 6'd2, 5'd4);
        step();
        check_eq("srl4", data_out, 32'h0800_0000);

        drive(1'b0, 32'd0, 32'h8000_0000, 6'd2, 5'd0);
        step();
        check_eq("srl0", data_out, 32'h8000_0000);

        drive(1'b0, 32'd0, 32'h8000_0000, 6'd2, 5'd31);
        step();
        check_eq("srl31", data_out, 32'd1);

`ifdef CPU_ALU_SLT_EN
        exp_slt_lt = 32'd1;
`else
        exp_slt_lt = 32'd0;
`endif
        drive(1'b0, 32'hFFFF_FFFF, 32'd1, 6'd42, 5'd0);
        step();
        check_eq("slt_lt", data_out, exp_slt_lt);

        drive(1'b0, 32'd1, 32'hFFFF_FFFF, 6'd42, 5'd0);
        step();
        check_eq("slt_ge", data_out, 32'd0);

        drive(1'b0, 32'd7, 32'd7, 6'd42, 5'd0);
        step();
        check_eq("slt_eq_zero", iszero, 1'b1);

        hilo = 64'h1234_5678_9ABC_DEF0;
        drive(1'b0, 32'd0, 32'd1, 6'd16, 5'd0);
        step();
        check_eq("mfhi", data_out, 32'h1234_5678);

        drive(1'b0, 32'd0, 32'd1, 6'd18, 5'd0);
        step();
        check_eq("mflo", data_out, 32'h9ABC_DEF0);

        drive(1'b1, 32'h100, 32'hFFFF_FFFC, 6'd42, 5'd0);
        step();
        check_eq("imm_add", data_out, 32'h0000_00FC);
        check_eq("imm_zero", iszero, 1'b0);

        drive(1'b1, 32'h44, 32'h44, 6'd34, 5'd0);
        step();
        check_eq("beq_add", data_out, 32'h88);
        check_eq("beq_zero", iszero, 1'b1);

        drive(1'b0, 32'd1, 32'd2, 6'd25, 5'd0);
        step();
        check_eq("multu_zero", data_out, 32'd0);

        drive(1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        step();
        check_eq("nop_zero", data_out, 32'd0);

        // Back-to-back: each result must appear exactly one edge after its inputs.
        drive(1'b0, 32'd10, 32'd20, 6'd32, 5'd0);
        step();
        drive(1'b0, 32'd50, 32'd8, 6'd34, 5'd0);
        check_eq("b2b_1", data_out, 32'd30);
        @(negedge clka);
        check_eq("b2b_1_hold", data_out, 32'd30);
        step();
        drive(1'b0, 32'hFF00, 32'h0FF0, 6'd36, 5'd0);
        check_eq("b2b_2", data_out, 32'd42);
        step();
        drive(1'b0, 32'h1234, 32'h1234, 6'd63, 5'd0);
        check_eq("b2b_3", data_out, 32'h0F00);
        step();
        check_eq("unknown63", data_out, 32'd0);
        check_eq("unknown63_zero", iszero, 1'b1);

        reset = 1'b1;
        drive(1'b0, 32'd1, 32'd1, 6'd32, 5'd0);
        step();
        check_eq("reset2_data", data_out, 32'd0);
        check_eq("reset2_zero", iszero, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
